// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_pkg;

  // Scanner phase: all anodes off, or one digit driven.
  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  // Active-low pattern with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_SCAN_DIV    = 50000;
  localparam int DEF_DEAD_CYCLES = 16;

  // Counter width for a count of n states; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_decoder.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} seven-segment pattern.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input nibble.
module SevenSegDecoder (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Table lookup; a 0 bit lights the segment.
  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h27;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: DRIVE one digit, BLANK dead time, next digit.
// Latency: outputs registered, an/seg follow the FSM state by one cycle; load lands in shadow next cycle, active on frame wrap.
// Backpressure: none; free-running while en=1. Optional SEG_LEAD_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int SCAN_DIV    = DEF_SCAN_DIV,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DIG_W = cnt_w(NUM_DIGITS);
  localparam int DRV_W = cnt_w(SCAN_DIV);
  localparam int DED_W = cnt_w(DEAD_CYCLES);

  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [DRV_W-1:0] DRV_LAST = DRV_W'(SCAN_DIV - 1);
  localparam logic [DED_W-1:0] DED_LAST = DED_W'(DEAD_CYCLES - 1);

  // FSM and scan position
  state_t           state_q;
  logic [DIG_W-1:0] digit_q;
  logic [DRV_W-1:0] drv_cnt_q;
  logic [DED_W-1:0] ded_cnt_q;
  logic             en_q;

  // Shadow (written by load) and active (displayed) data
  logic [4*NUM_DIGITS-1:0] shd_val_q, act_val_q;
  logic [NUM_DIGITS-1:0]   shd_dp_q,  act_dp_q;
  logic [NUM_DIGITS-1:0]   shd_blk_q, act_blk_q;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_n_q;
  logic                  fd_q;

  // Per-cycle decisions and current-digit selections
  logic                  start_scan;
  logic                  frame_wrap;
  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic                  blk_sel;
  logic                  lz_sel;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Scan start on the first enabled cycle; frame wrap at the end of the last digit's dead time.
  always_comb begin
    start_scan = en && !en_q;
    frame_wrap = en && en_q && (state_q == BLANK) &&
                 (ded_cnt_q == DED_LAST) && (digit_q == DIG_LAST);
  end

  // Digit-indexed mux feeding the single shared decoder.
  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    blk_sel = 1'b0;
    lz_sel  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_q == DIG_W'(i)) begin
        nib_sel = act_val_q[i*4 +: 4];
        dp_sel  = act_dp_q[i];
        blk_sel = act_blk_q[i];
        lz_sel  = lz_mask[i];
      end
    end
  end

`ifdef SEG_LEAD_ZERO_BLANK_EN
  logic lz_run;

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (act_val_q[i*4 +: 4] == 4'h0);
      lz_mask[i] = lz_run;
    end
  end
`else
  // Without leading-zero suppression only blank_in can darken a digit.
  always_comb begin
    lz_mask = '0;
  end
`endif

  SevenSegDecoder u_dec (
    .nib_i (nib_sel),
    .seg_o (dec_seg)
  );

  // Segment pattern and anode pattern for the digit currently being driven.
  always_comb begin
    seg_d = (blk_sel || lz_sel) ? SEG_OFF : dec_seg;
    an_d  = ~(NUM_DIGITS'(1) << digit_q);
  end

  // Shadow captures every load; active refreshes only at scan start or frame wrap, with load bypass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd_val_q <= '0;
      shd_dp_q  <= '0;
      shd_blk_q <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_blk_q <= '0;
    end else begin
      if (load) begin
        shd_val_q <= value;
        shd_dp_q  <= dp_in;
        shd_blk_q <= blank_in;
      end
      if (start_scan || frame_wrap) begin
        if (load) begin
          act_val_q <= value;
          act_dp_q  <= dp_in;
          act_blk_q <= blank_in;
        end else begin
          act_val_q <= shd_val_q;
          act_dp_q  <= shd_dp_q;
          act_blk_q <= shd_blk_q;
        end
      end
    end
  end

  // Scan FSM with phase counters; outputs registered from the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      digit_q   <= '0;
      drv_cnt_q <= '0;
      ded_cnt_q <= '0;
      en_q      <= 1'b0;
      an_q      <= '1;
      seg_q     <= SEG_OFF;
      dp_n_q    <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      en_q <= en;
      fd_q <= frame_wrap;

      if (!en) begin
        state_q   <= BLANK;
        digit_q   <= '0;
        drv_cnt_q <= '0;
        ded_cnt_q <= '0;
      end else if (!en_q) begin
        // Fresh start skips the dead time and drives digit 0 immediately.
        state_q   <= DRIVE;
        digit_q   <= '0;
        drv_cnt_q <= '0;
        ded_cnt_q <= '0;
      end else begin
        case (state_q)
          DRIVE: begin
            if (drv_cnt_q == DRV_LAST) begin
              state_q   <= BLANK;
              drv_cnt_q <= '0;
            end else begin
              drv_cnt_q <= drv_cnt_q + 1'b1;
            end
          end
          BLANK: begin
            if (ded_cnt_q == DED_LAST) begin
              state_q   <= DRIVE;
              ded_cnt_q <= '0;
              digit_q   <= (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
            end else begin
              ded_cnt_q <= ded_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q   <= BLANK;
            drv_cnt_q <= '0;
            ded_cnt_q <= '0;
          end
        endcase
      end

      if (en && (state_q == DRIVE)) begin
        an_q   <= an_d;
        seg_q  <= seg_d;
        dp_n_q <= ~dp_sel;
      end else begin
        an_q   <= '1;
        seg_q  <= SEG_OFF;
        dp_n_q <= 1'b1;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 4 drive cycles, 2 dead cycles.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, en, load;
  logic [15:0] value;
  logic [3:0]  dp_in, blank_in;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dpn;
    logic        exp_fd;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .DEAD_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .seg        (seg),
    .dp_n       (dp_n),
    .an         (an),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic add(input logic [3:0] a, input logic [6:0] s, input logic fd);
    vec_t v;
    v.en = 1'b1; v.load = 1'b0; v.value = 16'h0;
    v.exp_an = a; v.exp_seg = s; v.exp_dpn = 1'b1; v.exp_fd = fd;
    tbl.push_back(v);
  endtask

  // One full frame: per digit 4 driven rows then 2 dead rows; frame_done on the last.
  task automatic add_frame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) add(an_of(d), s[d], 1'b0);
      add(4'hF, 7'h7F, 1'b0);
      add(4'hF, 7'h7F, (d == 3) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic wait_fd(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (frame_done === 1'b1) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] hi_seg;
`ifdef SEG_LEAD_ZERO_BLANK_EN
    hi_seg = 7'h7F;
`else
    hi_seg = 7'h40;
`endif

    // Table: row 0 is the enable edge, then frame of 1234, then frame of ABCD.
    add(4'hF, 7'h7F, 1'b0);
    add_frame(7'h19, 7'h30, 7'h24, 7'h79);
    add_frame(7'h21, 7'h27, 7'h03, 7'h08);
    tbl[10].load  = 1'b1;
    tbl[10].value = 16'hABCD;

    // Reset state
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
    repeat (3) step();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dpn", 32'(dp_n), 32'd1);
    check("rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    step();

    // Load 1234 while disabled; display must stay dark.
    load = 1'b1; value = 16'h1234;
    step();
    load = 1'b0;
    step();
    check("idle_an", 32'(an), 32'hF);

    // Two frames from the table, mid-frame load of ABCD deferred to frame 2.
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; load = tbl[i].load; value = tbl[i].value;
      step();
      load = 1'b0;
      check($sformatf("vec%0d_an", i), 32'(an), 32'(tbl[i].exp_an));
      check($sformatf("vec%0d_seg", i), 32'(seg), 32'(tbl[i].exp_seg));
      check($sformatf("vec%0d_dpn", i), 32'(dp_n), 32'(tbl[i].exp_dpn));
      check($sformatf("vec%0d_fd", i), 32'(frame_done), 32'(tbl[i].exp_fd));
    end

    // Load on the frame-wrap cycle bypasses the shadow.
    repeat (23) step();
    check("byp_pre_fd", 32'(frame_done), 32'd0);
    load = 1'b1; value = 16'h00F0;
    step();
    load = 1'b0;
    check("byp_fd", 32'(frame_done), 32'd1);
    step();
    check("byp_d0_an", 32'(an), 32'hE);
    check("byp_d0_seg", 32'(seg), 32'h40);
    repeat (6) step();
    check("byp_d1_an", 32'(an), 32'hD);
    check("byp_d1_seg", 32'(seg), 32'h0E);
    repeat (6) step();
    check("byp_d2_an", 32'(an), 32'hB);
    check("byp_d2_seg", 32'(seg), 32'(hi_seg));
    repeat (6) step();
    check("byp_d3_an", 32'(an), 32'h7);
    check("byp_d3_seg", 32'(seg), 32'(hi_seg));

    // Per-digit blank and decimal point.
    load = 1'b1; value = 16'h1234; dp_in = 4'b0001; blank_in = 4'b0010;
    step();
    load = 1'b0;
    wait_fd("bd_wait_fd");
    step();
    check("bd_d0_an", 32'(an), 32'hE);
    check("bd_d0_seg", 32'(seg), 32'h19);
    check("bd_d0_dpn", 32'(dp_n), 32'd0);
    repeat (6) step();
    check("bd_d1_an", 32'(an), 32'hD);
    check("bd_d1_seg", 32'(seg), 32'h7F);
    check("bd_d1_dpn", 32'(dp_n), 32'd1);

    // Reset pulse in the middle of digit 2.
    repeat (7) step();
    check("mr_d2_an", 32'(an), 32'hB);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mr_an", 32'(an), 32'hF);
    check("mr_seg", 32'(seg), 32'h7F);
    check("mr_dpn", 32'(dp_n), 32'd1);
    check("mr_fd", 32'(frame_done), 32'd0);
    step();
    check("mr_start_an", 32'(an), 32'hF);
    step();
    check("mr_d0_an", 32'(an), 32'hE);
    check("mr_d0_seg", 32'(seg), 32'h40);

    // Enable low for 10 cycles, shadow loads meanwhile and appears on re-enable.
    en = 1'b0; load = 1'b1; value = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      load = 1'b0;
      check($sformatf("off%0d_an", i), 32'(an), 32'hF);
      check($sformatf("off%0d_fd", i), 32'(frame_done), 32'd0);
    end
    en = 1'b1;
    step();
    check("on_start_an", 32'(an), 32'hF);
    step();
    check("on_d0_an", 32'(an), 32'hE);
    check("on_d0_seg", 32'(seg), 32'h19);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
